// File: rtl/shiftreg_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : shiftreg_arbiter
// Function : Shares a free-running DEPTH-stage shift register between two
//            requesters. Chooses what enters stage 0 each clock (granted data
//            or a zero bubble), carries a valid/source tag pipeline aligned
//            with the data stages, and provides a flush/drain sequencer.
// Options  : `define SHIFTREG_ARB_FIXED_PRIO_EN -> requester 0 always wins
//            under contention (no round-robin pointer). Default: round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module shiftreg_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] sr_din,
  input  logic [WIDTH-1:0] sr_dout_last,
  output logic             out_valid,
  output logic             out_src,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [2:0]       inflight,
  output logic             flush_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             flush_done_q, flush_done_d;
  logic [DEPTH-1:0] tag_vld_q;
  logic [DEPTH-1:0] tag_src_q;

  logic             accept_en;
  logic             gnt_id;
  logic             gnt0, gnt1, xfer;
  logic [2:0]       cnt_all;
  logic [2:0]       cnt_head;

  // New grants are blocked while draining and in the cycle a flush arrives.
  assign accept_en = (state_q != ST_DRAIN) && !flush;

`ifdef SHIFTREG_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 1 only wins when requester 0 is idle.
  always_comb begin
    gnt_id = ~req0_valid;
  end
`else
  logic rr_q, rr_d;

  // Round-robin choice: the pointer only matters when both requesters are valid.
  always_comb begin
    gnt_id = req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_id = rr_q;
    end
  end

  // After a transfer, favour the requester that was not just served.
  always_comb begin
    rr_d = rr_q;
    if (xfer) begin
      rr_d = ~gnt1;
    end
  end

  // Round-robin pointer register; reset favours requester 0.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign gnt0       = accept_en && req0_valid && !gnt_id;
  assign gnt1       = accept_en && req1_valid &&  gnt_id;
  assign xfer       = gnt0 || gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Granted payload enters stage 0; otherwise a zero bubble is shifted in.
  always_comb begin
    sr_din = '0;
    if (gnt1) begin
      sr_din = req1_data;
    end else if (gnt0) begin
      sr_din = req0_data;
    end
  end

  // Stage-0 tag captures the transfer flag and its source (0 on bubbles).
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tag_vld_q[0] <= 1'b0;
      tag_src_q[0] <= 1'b0;
    end else begin
      tag_vld_q[0] <= xfer;
      tag_src_q[0] <= gnt1;
    end
  end

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_tag
      // Tag stage gi follows the data stage of the same index.
      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          tag_vld_q[gi] <= 1'b0;
          tag_src_q[gi] <= 1'b0;
        end else begin
          tag_vld_q[gi] <= tag_vld_q[gi-1];
          tag_src_q[gi] <= tag_src_q[gi-1];
        end
      end
    end
  endgenerate

  // Occupancy: all stages, and the stages that survive the next shift.
  always_comb begin
    cnt_all  = 3'd0;
    cnt_head = 3'd0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_all = cnt_all + 3'(tag_vld_q[i]);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      cnt_head = cnt_head + 3'(tag_vld_q[i]);
    end
  end

  // Sequencer: flush wins over grants; drain ends once the tags are empty.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (xfer) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (!xfer && (cnt_head == 3'd0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (tag_vld_q == '0) begin
          state_d      = ST_IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and drain-complete pulse registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign out_valid  = tag_vld_q[DEPTH-1];
  assign out_src    = tag_src_q[DEPTH-1];
  assign out_data   = out_valid ? sr_dout_last : '0;
  assign inflight   = cnt_all;
  assign busy       = (cnt_all != 3'd0);
  assign flush_done = flush_done_q;

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_shiftreg_arbiter
// Function : Self-checking bench for shiftreg_arbiter with an external 4-stage
//            shift register model. Expected values come from a log of accepted
//            words indexed by clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shiftreg_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int MAXE  = 4096;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             req0_valid, req1_valid, flush;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] sr_din, sr_dout_last, out_data;
  logic             out_valid, out_src, busy, flush_done;
  logic [2:0]       inflight;

  shiftreg_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .flush(flush), .sr_din(sr_din), .sr_dout_last(sr_dout_last),
    .out_valid(out_valid), .out_src(out_src), .out_data(out_data),
    .busy(busy), .inflight(inflight), .flush_done(flush_done)
  );

  always #5 Clock = ~Clock;

  // External free-running shift register sharing clock and reset.
  logic [WIDTH-1:0] sr_q [0:DEPTH-1];
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= sr_din;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign sr_dout_last = sr_q[DEPTH-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: per-edge log of accepted words plus drain/pointer bookkeeping.
  logic             acc_v [0:MAXE-1];
  logic             acc_s [0:MAXE-1];
  logic [WIDTH-1:0] acc_d [0:MAXE-1];
  int               ecnt     = 0;
  int               rst_edge = 0;
  logic             draining = 1'b0;
  logic             exp_fd   = 1'b0;
`ifndef SHIFTREG_ARB_FIXED_PRIO_EN
  logic             ptr      = 1'b0;
`endif

  function automatic int model_inflight();
    int n = 0;
    for (int k = ecnt - DEPTH + 1; k <= ecnt; k++) begin
      if (k > rst_edge && acc_v[k]) n++;
    end
    return n;
  endfunction

  task automatic check_outputs();
    int         n;
    int         k;
    logic       ov;
    logic       os;
    logic [7:0] od;
    n  = model_inflight();
    k  = ecnt - DEPTH + 1;
    ov = (k > rst_edge) ? acc_v[k] : 1'b0;
    os = ov ? acc_s[k] : 1'b0;
    od = ov ? acc_d[k] : 8'h00;
    check("out_valid",  32'(out_valid),  32'(ov));
    check("out_src",    32'(out_src),    32'(os));
    check("out_data",   32'(out_data),   32'(od));
    check("inflight",   32'(inflight),   32'(n));
    check("busy",       32'(busy),       32'(n != 0));
    check("flush_done", 32'(flush_done), 32'(exp_fd));
  endtask

  task automatic step(input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1, input logic fl);
    logic       g0, g1, xf;
    logic [7:0] din;
    int         pre;
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    flush      = fl;
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (!draining && !fl) begin
      if (v0 && v1) begin
`ifdef SHIFTREG_ARB_FIXED_PRIO_EN
        g0 = 1'b1;
`else
        if (ptr) g1 = 1'b1; else g0 = 1'b1;
`endif
      end else begin
        g0 = v0; g1 = v1;
      end
    end
    xf  = g0 | g1;
    din = g1 ? d1 : (g0 ? d0 : 8'h00);
    check("req0_ready", 32'(req0_ready), 32'(g0));
    check("req1_ready", 32'(req1_ready), 32'(g1));
    check("sr_din",     32'(sr_din),     32'(din));
    pre = model_inflight();
    @(posedge Clock);
    ecnt++;
    acc_v[ecnt] = xf; acc_s[ecnt] = g1; acc_d[ecnt] = din;
`ifndef SHIFTREG_ARB_FIXED_PRIO_EN
    if (xf) ptr = ~g1;
`endif
    exp_fd = draining && (pre == 0);
    if (exp_fd) draining = 1'b0;
    else if (!draining && fl) draining = 1'b1;
    #1;
    check_outputs();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    #1;
    Reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_inflight",  32'(inflight),  32'd0);
    rst_edge = ecnt;
    draining = 1'b0;
    exp_fd   = 1'b0;
`ifndef SHIFTREG_ARB_FIXED_PRIO_EN
    ptr      = 1'b0;
`endif
    check_outputs();
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    req0_valid = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_data = '0;
    flush = 1'b0;
    #2;
    check_outputs();
    @(posedge Clock);
    #3 Reset = 1'b1;

    // Single word from requester 0.
    step(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Continuous contention.
    repeat (8) step(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Requester 1 on alternate cycles (bubbles in between).
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, (i % 2) == 0, 8'h3C, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Fill the pipeline, flush with inflight=4, keep requesting during drain.
    repeat (4) step(1'b1, 8'h5A, 1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 8'hC3, 1'b1);
    repeat (7) step(1'b1, 8'h66, 1'b1, 8'h99, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Flush with an empty pipeline; request in the drain cycle must wait.
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h78, 1'b0, 8'h00, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Reset mid-stream with inflight=3, then contention restarts at requester 0.
    step(1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h03, 1'b0);
    mid_reset();
    repeat (4) step(1'b1, 8'h44, 1'b1, 8'h88, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           8'($urandom), $urandom_range(0, 15) == 0);
    end
    repeat (8) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
